// File: rtl/ga_fitness_arbiter.sv
// ga_fitness_arbiter
// Round-robin arbiter in front of a serial fitness evaluator. One requester
// is granted at a time; its chromosome and the target are captured on the
// grant edge, compared one gene per cycle, and the match count and
// percentage are presented on a valid/ready response port.
// Optional feature: define GA_ARB_GRANT_CNT_EN to add grant_cnt, one
// saturating 16-bit grant counter per requester.
module ga_fitness_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN     = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LEN*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [LEN*8-1:0]           target,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [$clog2(LEN+1)-1:0]   rsp_score,
  output logic [6:0]                 rsp_percent,
  output logic                       busy
`ifdef GA_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_cnt
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SC_W  = $clog2(LEN+1);
  localparam int IX_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PCT_W = 14;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [IX_W-1:0]    idx_q, idx_d;
  logic [SC_W-1:0]    score_q, score_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [SC_W-1:0]    rsp_score_q, rsp_score_d;
  logic [6:0]         rsp_percent_q, rsp_percent_d;
  logic [LEN*8-1:0]   chrom_q, target_q;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_id, cand;
  logic [LEN*8-1:0]   sel_chrom;
  logic [7:0]         gene_a, gene_t;
  logic [SC_W-1:0]    score_next;
  logic [PCT_W-1:0]   pct_wide;
  logic [NUM_REQ-1:0] ready_c;
  logic               capture;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // NOTE: combinational logic uses blocking '=', so later statements see the updated value; clocked state uses '<='.
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Mux out the granted requester's chromosome for capture.
  always_comb begin
    sel_chrom = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) sel_chrom = req_data[i*LEN*8 +: LEN*8];
    end
  end

  // Select the gene pair under comparison this EVAL cycle.
  always_comb begin
    gene_a = '0;
    gene_t = '0;
    for (int j = 0; j < LEN; j++) begin
      if (idx_q == IX_W'(j)) begin
        gene_a = chrom_q[j*8 +: 8];
        gene_t = target_q[j*8 +: 8];
      end
    end
  end

  // Next-state and output decode for the IDLE/EVAL/RESP controller.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    idx_d         = idx_q;
    score_d       = score_q;
    rsp_id_d      = rsp_id_q;
    rsp_score_d   = rsp_score_q;
    rsp_percent_d = rsp_percent_q;
    ready_c       = '0;
    capture       = 1'b0;
    score_next    = score_q + SC_W'(gene_a == gene_t);
    // 14-bit product keeps score*100 exact so a full match divides to 100.
    pct_wide      = (PCT_W'(score_next) * PCT_W'(100)) / PCT_W'(LEN);
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ready_c  = NUM_REQ'(1) << gnt_id;
          capture  = 1'b1;
          id_d     = gnt_id;
          rr_ptr_d = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
          idx_d    = '0;
          score_d  = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        score_d = score_next;
        if (idx_q == IX_W'(LEN-1)) begin
          idx_d         = '0;
          rsp_id_d      = id_q;
          rsp_score_d   = score_next;
          rsp_percent_d = 7'(pct_wide);
          state_d       = RESP;
        end else begin
          idx_d = idx_q + IX_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      idx_q         <= '0;
      score_q       <= '0;
      rsp_id_q      <= '0;
      rsp_score_q   <= '0;
      rsp_percent_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      idx_q         <= idx_d;
      score_q       <= score_d;
      rsp_id_q      <= rsp_id_d;
      rsp_score_q   <= rsp_score_d;
      rsp_percent_q <= rsp_percent_d;
    end
  end

  // Capture chromosome and target on the grant edge.
  // NOTE: these datapath registers have no reset; they are always written on a grant before EVAL reads them.
  always_ff @(posedge clk) begin
    if (capture) begin
      chrom_q  <= sel_chrom;
      target_q <= target;
    end
  end

`ifdef GA_ARB_GRANT_CNT_EN
  logic [NUM_REQ*16-1:0] grant_cnt_q;

  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture && gnt_id == ID_W'(i) && grant_cnt_q[i*16 +: 16] != 16'hFFFF)
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

  // The grant pulse is combinational from IDLE; gating with rst_n keeps it
  // low while reset is held even if requests are pending.
  assign req_ready   = rst_n ? ready_c : '0;
  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_id      = rsp_id_q;
  assign rsp_score   = rsp_score_q;
  assign rsp_percent = rsp_percent_q;

endmodule

// File: tb/tb_ga_fitness_arbiter.sv
// tb_ga_fitness_arbiter
// Scoreboard bench: a negedge monitor predicts each grant from its own
// round-robin model, pushes the expected result computed from the request
// data at grant time, and pops/compares on every response handshake.
module tb_ga_fitness_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LEN     = 12;
  localparam int CW      = LEN*8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CW-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [CW-1:0]            target;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [3:0]               rsp_score;
  logic [6:0]               rsp_percent;
  logic                     busy;
`ifdef GA_ARB_GRANT_CNT_EN
  logic [NUM_REQ*16-1:0]    grant_cnt;
`endif

  always #5 clk = ~clk;

  ga_fitness_arbiter #(.NUM_REQ(NUM_REQ), .LEN(LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .target      (target),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_score   (rsp_score),
    .rsp_percent (rsp_percent),
    .busy        (busy)
`ifdef GA_ARB_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  typedef struct {
    int id;
    int score;
    int pct;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int score_of(input logic [CW-1:0] a, input logic [CW-1:0] b);
    int s;
    s = 0;
    for (int j = 0; j < LEN; j++) if (a[j*8 +: 8] == b[j*8 +: 8]) s++;
    return s;
  endfunction

  function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] v, input int ptr);
    int c;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (ptr + k) % NUM_REQ;
      if (v[c]) return NUM_REQ'(1) << c;
    end
    return '0;
  endfunction

  // Chromosome matching the current target in genes 0..n-1 only.
  function automatic logic [CW-1:0] make(input int n);
    logic [CW-1:0] c;
    c = target;
    for (int j = 0; j < LEN; j++) if (j >= n) c[j*8 +: 8] = ~target[j*8 +: 8];
    return c;
  endfunction

  int                 cyc = 0;
  int                 grant_cyc = -1000;
  bit                 m_busy = 1'b0;
  int                 rr_m = 0;
  int                 grant_count = 0;
  int                 last_gnt = -1;
  bit [NUM_REQ-1:0]   gnt_seen = '0;
  int                 gnt_log[$];
  bit                 chk_spacing = 1'b0;
  bit                 spacing_armed = 1'b0;
  int                 cnt_m[NUM_REQ];
  logic [NUM_REQ-1:0] exp_rdy;
  int                 gid;
  int                 gsc;
  rsp_t               r;

  // Monitor: sample away from the rising edge and compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy    = 1'b0;
      rr_m      = 0;
      grant_cyc = -1000;
      sb.delete();
      for (int i = 0; i < NUM_REQ; i++) cnt_m[i] = 0;
    end else begin
      cyc++;
      check("busy", busy, m_busy);
      check("rsp_valid", rsp_valid, m_busy && (cyc - grant_cyc >= LEN + 1));
      exp_rdy = m_busy ? '0 : pick(req_valid, rr_m);
      check("req_ready", req_ready, exp_rdy);
      if (exp_rdy != '0) begin
        gid = 0;
        for (int i = 0; i < NUM_REQ; i++) if (exp_rdy[i]) gid = i;
        gsc = score_of(req_data[gid*CW +: CW], target);
        sb.push_back('{gid, gsc, (gsc * 100) / LEN});
        if (chk_spacing) begin
          if (spacing_armed) check("grant_spacing", cyc - grant_cyc, LEN + 2);
          spacing_armed = 1'b1;
        end
        rr_m          = (gid + 1) % NUM_REQ;
        m_busy        = 1'b1;
        grant_cyc     = cyc;
        grant_count++;
        last_gnt      = gid;
        gnt_seen[gid] = 1'b1;
        gnt_log.push_back(gid);
        if (cnt_m[gid] < 65535) cnt_m[gid]++;
      end
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          r = sb.pop_front();
          check("rsp_id", rsp_id, r.id);
          check("rsp_score", rsp_score, r.score);
          check("rsp_percent", rsp_percent, r.pct);
        end
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_gnt(input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (gnt_seen[id]) begin ok = 1'b1; break; end
    end
    check("grant_timeout", ok, 1);
  endtask

  task automatic request_one(input int id);
    gnt_seen[id]  = 1'b0;
    req_valid[id] = 1'b1;
    wait_gnt(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
    check("idle_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (grant_count >= n) begin ok = 1'b1; break; end
    end
    check("grants_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_rsp_id"}, rsp_id, 0);
    check({pfx, "_rsp_score"}, rsp_score, 0);
    check({pfx, "_rsp_percent"}, rsp_percent, 0);
`ifdef GA_ARB_GRANT_CNT_EN
    check({pfx, "_grant_cnt"}, grant_cnt, 0);
`endif
  endtask

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  logic [CW-1:0] hw;
  int            exp_ord[6];
  int            g0;
  logic [1:0]    cap_id;
  logic [3:0]    cap_sc;
  logic [6:0]    cap_pct;
  bit            ok_v;

  initial begin
    hw         = "Hello World!";
    exp_ord    = '{0, 1, 2, 3, 0, 3};
    req_valid  = '0;
    req_data   = '0;
    target     = '0;
    rsp_ready  = 1'b1;

    // Power-on reset.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact match on requester 0.
    target            = hw;
    req_data[0 +: CW] = hw;
    request_one(0);
    wait_idle();

    // Partial matches: 6, 1 and 0 genes.
    req_data[1*CW +: CW] = make(6);
    request_one(1);
    wait_idle();
    req_data[2*CW +: CW] = make(1);
    request_one(2);
    wait_idle();
    req_data[3*CW +: CW] = make(0);
    request_one(3);
    wait_idle();

    // Fairness with all requesters held, then only 0 and 3.
    req_data[0*CW +: CW] = make(3);
    req_data[1*CW +: CW] = make(9);
    req_data[2*CW +: CW] = make(12);
    req_data[3*CW +: CW] = make(5);
    gnt_log.delete();
    spacing_armed = 1'b0;
    chk_spacing   = 1'b1;
    g0            = grant_count;
    req_valid     = 4'b1111;
    wait_grants(g0 + 4);
    req_valid     = 4'b1001;
    wait_grants(g0 + 6);
    req_valid     = 4'b0000;
    chk_spacing   = 1'b0;
    wait_idle();
    check("order_len", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) check("grant_order", gnt_log[i], exp_ord[i]);

    // Backpressure: hold the response for 20 cycles with another request pending.
    rsp_ready            = 1'b0;
    req_data[1*CW +: CW] = make(10);
    req_data[2*CW +: CW] = make(2);
    request_one(1);
    req_valid[2] = 1'b1;
    ok_v = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin ok_v = 1'b1; break; end
    end
    check("bp_rsp_timeout", ok_v, 1);
    cap_id  = rsp_id;
    cap_sc  = rsp_score;
    cap_pct = rsp_percent;
    check("bp_cap_id", cap_id, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, cap_id);
      check("bp_score", rsp_score, cap_sc);
      check("bp_pct", rsp_percent, cap_pct);
      check("bp_no_ready", req_ready, 0);
    end
    gnt_seen[2] = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_handshake_busy", busy, 1);
    @(negedge clk); #1;
    check("bp_idle", busy, 0);
    check("bp_regrant", gnt_seen[2], 1);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_idle();

    // Reset in the middle of EVAL; requester 2 waiting throughout.
    req_data[0*CW +: CW] = make(4);
    request_one(0);
    req_valid[2] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_eval_rst");
    @(negedge clk); #1;
    check_reset_outputs("rst_held");
    gnt_seen = '0;
    @(posedge clk); #2 rst_n = 1'b1;
    wait_gnt(2);
    check("rst_first_grant", last_gnt, 2);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_idle();

    // Isolation: corrupt target and request data during EVAL.
    target               = {$urandom, $urandom, $urandom};
    req_data[3*CW +: CW] = make(7);
    request_one(3);
    target               = ~target;
    req_data[3*CW +: CW] = {$urandom, $urandom, $urandom};
    wait_idle();

    // Three grants to requester 1 with random match counts.
    for (int k = 0; k < 3; k++) begin
      req_data[1*CW +: CW] = make($urandom_range(0, LEN));
      request_one(1);
      wait_idle();
    end

`ifdef GA_ARB_GRANT_CNT_EN
    check("grant_cnt_1", grant_cnt[31:16], 3);
    for (int i = 0; i < NUM_REQ; i++) check("grant_cnt_model", grant_cnt[i*16 +: 16], cnt_m[i]);
`endif

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ga_fitness_arbiter.md
GA_FITNESS_ARBITER -- requirements
Module: ga_fitness_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 4, number of requesters (2..8); LEN, 12, genes per chromosome (1..32).
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: req_valid  in  NUM_REQ  per-requester evaluation request.
REQ-005 Port: req_data  in  NUM_REQ*LEN*8  chromosomes. Requester i, gene j is at bits [(i*LEN+j)*8 +: 8].
REQ-006 Port: req_ready  out  NUM_REQ  one-hot grant/accept pulse.
REQ-007 Port: target  in  LEN*8  target chromosome. Gene j is at bits [j*8 +: 8].
REQ-008 Port: rsp_valid  out  1  result available.
REQ-009 Port: rsp_ready  in  1  consumer accepts the result.
REQ-010 Port: rsp_id  out  $clog2(NUM_REQ)  index of the granted requester.
REQ-011 Port: rsp_score  out  $clog2(LEN+1)  count of matching genes.
REQ-012 Port: rsp_percent  out  7  floor(rsp_score*100/LEN).
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EVAL and RESP.
REQ-015 IDLE with any req_valid high:
- Grant the first requester with req_valid high, searching from rr_ptr upward, modulo NUM_REQ.
- Pulse that requester's req_ready for exactly one cycle.
- Capture its chromosome, the target and its id on that edge.
- Set rr_ptr = (granted id + 1) mod NUM_REQ.
- Go to EVAL.
REQ-016 IDLE with all req_valid low: hold state; req_ready = 0.
REQ-017 EVAL SHALL compare one gene per cycle (index 0 to LEN-1) against the captured target, incrementing the score on equality. It SHALL spend exactly LEN cycles in EVAL, then go to RESP.
REQ-018 RESP SHALL assert rsp_valid, with rsp_id, rsp_score and rsp_percent stable, until the cycle rsp_ready is high. On that edge it SHALL go to IDLE.
REQ-019 Latency: the grant edge to the first rsp_valid cycle SHALL be LEN+1 cycles. With rsp_ready held high, successive grants SHALL be LEN+2 cycles apart.
REQ-020 rsp_percent SHALL be computed with at least 14-bit intermediate width, so that rsp_score=LEN yields exactly 100.
REQ-021 req_ready SHALL NOT assert outside IDLE. Requests arriving during EVAL or RESP wait; requesters hold req_valid and req_data until granted.
REQ-022 Changes to req_data or target after the grant edge SHALL NOT affect the in-flight result.
REQ-023 A requester dropping req_valid before its grant SHALL NOT be granted.
REQ-024 rr_ptr wrap: after granting NUM_REQ-1, the search SHALL start at 0.
REQ-025 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force all of the following, including mid-EVAL or mid-RESP (any in-flight result is discarded):
- state = IDLE, rr_ptr = 0
- req_ready = 0, rsp_valid = 0, busy = 0
- rsp_id = 0, rsp_score = 0, rsp_percent = 0
- internal gene index and score = 0
REQ-027 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-028 Macro GA_ARB_GRANT_CNT_EN defined: the block SHALL add output grant_cnt, NUM_REQ*16 bits.
- Counter i is at bits [i*16 +: 16].
- Counter i increments on each grant to requester i and saturates at 16'hFFFF.
- All counters reset to 0.
REQ-029 Macro GA_ARB_GRANT_CNT_EN undefined: the port and counters SHALL be absent, with no other behaviour change.

Verification
REQ-030 Exact match: target="Hello World!"; req_valid=4'b0001 with an identical chromosome -> req_ready=4'b0001 for 1 cycle; LEN+1 cycles later rsp_valid=1, rsp_id=0, rsp_score=12, rsp_percent=100.
REQ-031 Partial match: 6 of 12 genes match -> rsp_score=6, rsp_percent=50. 1 match -> rsp_percent=8. 0 matches -> rsp_percent=0.
REQ-032 Fairness: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 at LEN+2-cycle spacing. Then req_valid=4'b1001 after granting 3 -> next grant 0.
REQ-033 Backpressure: rsp_ready=0 for 20 cycles in RESP -> rsp_valid stays 1 with outputs stable and no req_ready pulse. Raise rsp_ready -> IDLE next cycle, then a new grant.
REQ-034 Reset mid-EVAL: assert rst_n=0 at EVAL cycle 5 -> all outputs 0 asynchronously. After release with req_valid=4'b0100 -> grant to 2 (rr_ptr back at 0).
REQ-035 Isolation and counters: change target and req_data during EVAL -> result matches the captured values. With GA_ARB_GRANT_CNT_EN defined and 3 grants to requester 1 -> grant_cnt[31:16]=3.
